dot_acc: RTL and testbench

DOT_ACC -- requirements
Module: dot_acc

---
 rtl/dot_acc.sv | 129 ++++++++++++
 tb/tb_dot_acc.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_acc.sv
// Signed dot-product accumulator: sums 8-bit products into a saturating
// ACC_W-bit accumulator and holds each vector result until it is consumed downstream.
module dot_acc #(
  parameter int ACC_W   = 12,
  parameter int MAX_LEN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [7:0]       out_count,
  output logic             out_sat,
  output logic             out_trunc
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam logic [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [7:0]       MAX_LEN_C = 8'(MAX_LEN);

  // Clamp a one-bit-wider two's-complement sum back into ACC_W bits.
  function automatic logic [ACC_W-1:0] sat_trim(input logic [ACC_W:0] wide);
    logic ovf;
    ovf = wide[ACC_W] ^ wide[ACC_W-1];
    if (!ovf) begin
      sat_trim = wide[ACC_W-1:0];
    end else if (wide[ACC_W]) begin
      sat_trim = ACC_MIN;
    end else begin
      sat_trim = ACC_MAX;
    end
  endfunction

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       count_q, count_d;
  logic             sat_q, sat_d;
  logic             trunc_q, trunc_d;

  logic [ACC_W:0]   sum_wide_s;
  logic             clamp_s;
  logic             accept_s;
  logic [7:0]       count_inc_s;

  assign sum_wide_s  = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-7){in_prod[7]}}, in_prod};
  assign clamp_s     = sum_wide_s[ACC_W] ^ sum_wide_s[ACC_W-1];
  assign accept_s    = in_valid && (state_q == ACCUM);
  assign count_inc_s = count_q + 8'd1;

  // Next-state logic for the accumulate/hold handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    sat_d   = sat_q;
    trunc_d = trunc_q;
    case (state_q)
      ACCUM: begin
        if (accept_s) begin
          acc_d   = sat_trim(sum_wide_s);
          count_d = count_inc_s;
          sat_d   = sat_q | clamp_s;
          if (in_last) begin
            state_d = HOLD;
          end else if (count_inc_s == MAX_LEN_C) begin
            state_d = HOLD;
            trunc_d = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          count_d = 8'd0;
          sat_d   = 1'b0;
          trunc_d = 1'b0;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = ACCUM;
        acc_d   = '0;
        count_d = 8'd0;
        sat_d   = 1'b0;
        trunc_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset wins over any handshake on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      count_q <= 8'd0;
      sat_q   <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      sat_q   <= sat_d;
      trunc_q <= trunc_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = acc_q;
  assign out_count = count_q;
  assign out_sat   = sat_q;
  assign out_trunc = trunc_q;

endmodule

// File: tb/tb_dot_acc.sv
// Bench for dot_acc: a default-width and a 10-bit instance share stimulus and
// are checked against an integer-arithmetic model of the vector sum rules.
module tb_dot_acc;

  localparam int MAX_LEN = 16;

  logic clk = 1'b0;
  logic rst, in_valid, in_last, out_ready;
  logic [7:0] in_prod;

  logic r12, v12, st12, tr12, r10, v10, st10, tr10;
  logic [11:0] s12;
  logic [9:0]  s10;
  logic [7:0]  c12, c10;

  int n_pass = 0;
  int n_total = 0;

  int m_acc12, m_acc10, m_cnt;
  bit m_sat12, m_sat10, m_trunc, m_hold;

  always #5 clk = ~clk;

  dot_acc u12 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r12), .in_prod(in_prod),
    .in_last(in_last), .out_valid(v12), .out_ready(out_ready), .out_sum(s12),
    .out_count(c12), .out_sat(st12), .out_trunc(tr12)
  );

  dot_acc #(.ACC_W(10), .MAX_LEN(16)) u10 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r10), .in_prod(in_prod),
    .in_last(in_last), .out_valid(v10), .out_ready(out_ready), .out_sum(s10),
    .out_count(c10), .out_sat(st10), .out_trunc(tr10)
  );

  task automatic add_sat(inout int acc, inout bit s, input int p, input int w);
    int lim;
    int v;
    lim = 1 << (w - 1);
    v = acc + p;
    if (v > lim - 1) begin
      v = lim - 1;
      s = 1'b1;
    end else if (v < -lim) begin
      v = -lim;
      s = 1'b1;
    end
    acc = v;
  endtask

  task automatic model_clear();
    m_acc12 = 0; m_acc10 = 0; m_cnt = 0;
    m_sat12 = 0; m_sat10 = 0; m_trunc = 0; m_hold = 0;
  endtask

  // Behaviour of one clock edge given the inputs currently applied.
  task automatic model_edge();
    int p;
    if (rst) begin
      model_clear();
    end else if (!m_hold) begin
      if (in_valid) begin
        p = int'($signed(in_prod));
        add_sat(m_acc12, m_sat12, p, 12);
        add_sat(m_acc10, m_sat10, p, 10);
        m_cnt++;
        if (in_last) m_hold = 1;
        else if (m_cnt == MAX_LEN) begin
          m_hold = 1;
          m_trunc = 1;
        end
      end
    end else if (out_ready) begin
      model_clear();
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int p, input bit l);
    in_valid = v;
    in_prod = 8'(p);
    in_last = l;
  endtask

  task automatic test_reset();
    rst = 1; out_ready = 0;
    drive(1, 17, 1);
    tick(); tick();
    rst = 0;
    drive(0, 0, 0);
    n_total++; if (r12 !== 1'b1 || r10 !== 1'b1) $display("FAIL reset_ready got %b/%b want 1", r12, r10); else n_pass++;
    n_total++; if (v12 !== 1'b0 || v10 !== 1'b0) $display("FAIL reset_valid got %b/%b want 0", v12, v10); else n_pass++;
    n_total++; if (s12 !== 12'd0 || s10 !== 10'd0 || c12 !== 8'd0) $display("FAIL reset_sum got %0d/%0d cnt %0d want 0", s12, s10, c12); else n_pass++;
    n_total++; if (st12 !== 1'b0 || tr12 !== 1'b0 || st10 !== 1'b0) $display("FAIL reset_flags got sat %b trunc %b want 0", st12, tr12); else n_pass++;
  endtask

  task automatic test_basic();
    out_ready = 1;
    drive(1, 3, 0);  tick();
    n_total++; if ($signed(s12) !== 3 || c12 !== 8'd1) $display("FAIL basic_running got %0d cnt %0d want 3 cnt 1", $signed(s12), c12); else n_pass++;
    drive(1, -5, 0); tick();
    drive(1, 7, 1);  tick();
    drive(0, 0, 0);
    n_total++; if (v12 !== 1'b1 || r12 !== 1'b0) $display("FAIL basic_valid got v %b r %b want v 1 r 0", v12, r12); else n_pass++;
    n_total++; if ($signed(s12) !== 5 || $signed(s10) !== 5) $display("FAIL basic_sum got %0d/%0d want 5", $signed(s12), $signed(s10)); else n_pass++;
    n_total++; if (c12 !== 8'd3 || st12 !== 1'b0 || tr12 !== 1'b0) $display("FAIL basic_meta got cnt %0d sat %b trunc %b want 3 0 0", c12, st12, tr12); else n_pass++;
    tick();
    n_total++; if (r12 !== 1'b1 || v12 !== 1'b0 || c12 !== 8'd0) $display("FAIL basic_release got r %b v %b cnt %0d want 1 0 0", r12, v12, c12); else n_pass++;
  endtask

  task automatic test_saturation();
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin drive(1, 127, i == 4); tick(); end
    drive(0, 0, 0);
    n_total++; if ($signed(s10) !== 511 || st10 !== 1'b1 || c10 !== 8'd5) $display("FAIL sat_pos10 got %0d sat %b cnt %0d want 511 1 5", $signed(s10), st10, c10); else n_pass++;
    n_total++; if ($signed(s12) !== 635 || st12 !== 1'b0) $display("FAIL sat_pos12 got %0d sat %b want 635 0", $signed(s12), st12); else n_pass++;
    tick();
    for (int i = 0; i < 5; i++) begin drive(1, -128, i == 4); tick(); end
    drive(0, 0, 0);
    n_total++; if ($signed(s10) !== -512 || st10 !== 1'b1) $display("FAIL sat_neg10 got %0d sat %b want -512 1", $signed(s10), st10); else n_pass++;
    n_total++; if ($signed(s12) !== -640 || st12 !== 1'b0) $display("FAIL sat_neg12 got %0d sat %b want -640 0", $signed(s12), st12); else n_pass++;
    tick();
    n_total++; if (st10 !== 1'b0 || s10 !== 10'd0) $display("FAIL sat_clear got sat %b sum %0d want 0 0", st10, s10); else n_pass++;
  endtask

  task automatic test_boundary();
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      drive(1, -128, i == 15); tick();
      if (i == 14) begin
        n_total++; if (r12 !== 1'b1 || v12 !== 1'b0 || c12 !== 8'd15) $display("FAIL bound_15 got r %b v %b cnt %0d want 1 0 15", r12, v12, c12); else n_pass++;
      end
    end
    drive(0, 0, 0);
    n_total++; if ($signed(s12) !== -2048 || st12 !== 1'b0 || tr12 !== 1'b0 || c12 !== 8'd16) $display("FAIL bound_last got %0d sat %b trunc %b cnt %0d want -2048 0 0 16", $signed(s12), st12, tr12, c12); else n_pass++;
    tick();
    for (int i = 0; i < 16; i++) begin drive(1, -128, 0); tick(); end
    drive(0, 0, 0);
    n_total++; if (v12 !== 1'b1 || tr12 !== 1'b1 || tr10 !== 1'b1 || c12 !== 8'd16) $display("FAIL bound_trunc got v %b trunc %b cnt %0d want 1 1 16", v12, tr12, c12); else n_pass++;
    n_total++; if ($signed(s12) !== -2048 || $signed(s10) !== -512) $display("FAIL bound_trunc_sum got %0d/%0d want -2048/-512", $signed(s12), $signed(s10)); else n_pass++;
    tick();
    n_total++; if (tr12 !== 1'b0 || r12 !== 1'b1) $display("FAIL bound_clear got trunc %b r %b want 0 1", tr12, r12); else n_pass++;
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    drive(1, 2, 0); tick();
    drive(1, 3, 1); tick();
    for (int i = 0; i < 6; i++) begin
      drive(1, int'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);
      tick();
      n_total++;
      if ($signed(s12) !== 5 || c12 !== 8'd2 || v12 !== 1'b1 || r12 !== 1'b0 || st12 !== 1'b0 || tr12 !== 1'b0)
        $display("FAIL bp_hold%0d got sum %0d cnt %0d v %b r %b want 5 2 1 0", i, $signed(s12), c12, v12, r12);
      else n_pass++;
    end
    out_ready = 1;
    drive(0, 0, 0); tick();
    n_total++; if (r12 !== 1'b1 || v12 !== 1'b0 || c12 !== 8'd0 || s12 !== 12'd0) $display("FAIL bp_release got r %b v %b cnt %0d sum %0d want 1 0 0 0", r12, v12, c12, s12); else n_pass++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1;
    drive(1, 4, 0); tick();
    drive(1, 4, 0); tick();
    drive(1, 4, 0); rst = 1; tick();
    rst = 0; drive(0, 0, 0);
    n_total++; if (r12 !== 1'b1 || v12 !== 1'b0 || s12 !== 12'd0 || c12 !== 8'd0) $display("FAIL rstmid got r %b v %b sum %0d cnt %0d want 1 0 0 0", r12, v12, s12, c12); else n_pass++;
    tick();
    n_total++; if (v12 !== 1'b0) $display("FAIL rstmid_novalid got %b want 0", v12); else n_pass++;
    drive(1, 2, 1); tick();
    drive(0, 0, 0);
    n_total++; if (v12 !== 1'b1 || $signed(s12) !== 2 || c12 !== 8'd1) $display("FAIL rstmid_new got v %b sum %0d cnt %0d want 1 2 1", v12, $signed(s12), c12); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    int p[4];
    int sched[6];
    bit expv;
    for (int i = 0; i < 4; i++) p[i] = int'($urandom_range(0, 127)) - 64;
    sched = '{0, 1, 2, 2, 3, 3};
    out_ready = 1;
    for (int c = 0; c < 6; c++) begin
      drive(1, p[sched[c]], sched[c] % 2 == 1);
      tick();
      expv = (c == 1) || (c == 4);
      n_total++; if (v12 !== expv || r12 !== !expv) $display("FAIL b2b_cycle%0d got v %b r %b want v %b", c, v12, r12, expv); else n_pass++;
      if (c == 1) begin
        n_total++; if ($signed(s12) !== p[0] + p[1] || c12 !== 8'd2) $display("FAIL b2b_sum0 got %0d want %0d", $signed(s12), p[0] + p[1]); else n_pass++;
      end
      if (c == 4) begin
        n_total++; if ($signed(s12) !== p[2] + p[3] || c12 !== 8'd2) $display("FAIL b2b_sum1 got %0d want %0d", $signed(s12), p[2] + p[3]); else n_pass++;
      end
    end
    drive(0, 0, 0); tick();
  endtask

  task automatic test_random();
    bit ok;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)), $urandom_range(0, 4) == 0);
      tick();
      ok = (r12 === !m_hold) && (r10 === !m_hold) && (v12 === m_hold) && (v10 === m_hold)
        && ($signed(s12) === m_acc12) && ($signed(s10) === m_acc10)
        && (c12 === 8'(m_cnt)) && (c10 === 8'(m_cnt))
        && (st12 === m_sat12) && (st10 === m_sat10) && (tr12 === m_trunc) && (tr10 === m_trunc);
      n_total++;
      if (!ok)
        $display("FAIL rand_cycle%0d got v %b sum %0d/%0d cnt %0d sat %b/%b trunc %b want v %b sum %0d/%0d cnt %0d sat %b/%b trunc %b",
                 c, v12, $signed(s12), $signed(s10), c12, st12, st10, tr12,
                 m_hold, m_acc12, m_acc10, m_cnt, m_sat12, m_sat10, m_trunc);
      else n_pass++;
    end
    rst = 0;
  endtask

  initial begin
    rst = 1; in_valid = 0; in_prod = 8'd0; in_last = 0; out_ready = 0;
    model_clear();
    test_reset();
    test_basic();
    test_saturation();
    test_boundary();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
